// File: rtl/combat_round_ctrl.sv
// combat_round_ctrl
//   Per-frame combat scheduler for two players. It derives the hitbox and
//   hurtbox rectangles from each sprite origin and facing, resolves hits with
//   a two-stage pipeline, and owns health, hitstun and the round sequence
//   COUNTDOWN -> FIGHT -> KO -> COUNTDOWN.
//
// Ports
//   clk, reset            pixel clock, asynchronous active-high reset
//   SCEN                  one-clk frame strobe; the timer and hitstun advance only on it
//   pN_pos_x/pN_pos_y     sprite origin (10-bit, unsigned)
//   pN_facing             1 = facing right
//   pN_attack_active      whole attack animation window (clears the hit-latch when low)
//   pN_attack_damage      damaging sub-window of the attack
//   pN_health             current health
//   pN_hitstun            hitstun counter is non-zero
//   pN_hit_pulse          one-clk pulse when this player takes damage
//   pN_enable             move/attack enable (FIGHT and not in hitstun), registered
//   round_state           0 COUNTDOWN, 1 FIGHT, 2 KO (also serves as FSM debug view)
//   winner                00 none, 01 P1, 10 P2, 11 double KO; valid in KO
//
// Timing: SCEN at clk edge E0 latches the raw overlaps (stage 1); edge E1
// applies qualified damage (stage 2); edge E2 sees the new health and can
// enter KO. SCEN may arrive again while stage 2 is pending.
module combat_round_ctrl #(
    parameter int HP_MAX         = 100,
    parameter int DMG            = 10,
    parameter int HITSTUN_FRAMES = 12,
    parameter int READY_FRAMES   = 60,
    parameter int KO_FRAMES      = 120,
    parameter int HITBOX_W       = 40,
    parameter int HITBOX_H       = 80,
    parameter int HURTBOX_W      = 40,
    parameter int HURTBOX_H      = 45
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic [9:0] p1_pos_x,
    input  logic [9:0] p2_pos_x,
    input  logic [9:0] p1_pos_y,
    input  logic [9:0] p2_pos_y,
    input  logic       p1_facing,
    input  logic       p2_facing,
    input  logic       p1_attack_active,
    input  logic       p2_attack_active,
    input  logic       p1_attack_damage,
    input  logic       p2_attack_damage,
    output logic [7:0] p1_health,
    output logic [7:0] p2_health,
    output logic       p1_hitstun,
    output logic       p2_hitstun,
    output logic       p1_hit_pulse,
    output logic       p2_hit_pulse,
    output logic       p1_enable,
    output logic       p2_enable,
    output logic [1:0] round_state,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        ST_COUNTDOWN = 2'd0,
        ST_FIGHT     = 2'd1,
        ST_KO        = 2'd2
    } state_t;

    localparam logic signed [10:0] C_HB_W     = 11'(HITBOX_W);
    localparam logic signed [10:0] C_HB_H     = 11'(HITBOX_H);
    localparam logic signed [10:0] C_HU_W     = 11'(HURTBOX_W);
    localparam logic signed [10:0] C_HU_H     = 11'(HURTBOX_H);
    localparam logic signed [10:0] C_HB_OFF_L = 11'(35 - HITBOX_W);
    localparam logic [7:0]         C_HP       = 8'(HP_MAX);
    localparam logic [7:0]         C_DMG      = 8'(DMG);
    localparam logic [7:0]         C_STUN     = 8'(HITSTUN_FRAMES);
    localparam logic [7:0]         C_READY    = 8'(READY_FRAMES);
    localparam logic [7:0]         C_KO       = 8'(KO_FRAMES);

    state_t     r_state;
    logic [7:0] r_timer;
    logic [7:0] r_hp1, r_hp2;
    logic [7:0] r_stun1, r_stun2;
    logic       r_latch1, r_latch2;
    logic       r_hit12, r_hit21;
    logic       r_s2;
    logic       r_pulse1, r_pulse2;
    logic       r_en1, r_en2;
    logic [1:0] r_winner;

    // Geometry in 11-bit signed so boxes hanging off the left/top edge compare correctly.
    logic signed [10:0] w_p1_x, w_p1_y, w_p2_x, w_p2_y;
    logic signed [10:0] w_hb1_x0, w_hb1_y0, w_hb2_x0, w_hb2_y0;
    logic signed [10:0] w_hu1_x0, w_hu1_y0, w_hu2_x0, w_hu2_y0;
    logic               w_ov12, w_ov21;
    logic               w_q12, w_q21;

    always_comb begin
        w_p1_x   = signed'({1'b0, p1_pos_x});
        w_p1_y   = signed'({1'b0, p1_pos_y});
        w_p2_x   = signed'({1'b0, p2_pos_x});
        w_p2_y   = signed'({1'b0, p2_pos_y});
        w_hb1_x0 = p1_facing ? w_p1_x + 11'sd85 : w_p1_x + C_HB_OFF_L;
        w_hb2_x0 = p2_facing ? w_p2_x + 11'sd85 : w_p2_x + C_HB_OFF_L;
        w_hb1_y0 = w_p1_y - 11'sd5;
        w_hb2_y0 = w_p2_y - 11'sd5;
        w_hu1_x0 = w_p1_x + 11'sd40;
        w_hu2_x0 = w_p2_x + 11'sd40;
        w_hu1_y0 = w_p1_y + 11'sd53;
        w_hu2_y0 = w_p2_y + 11'sd53;
        // Half-open rectangle overlap: touching edges do not count.
        w_ov12 = (w_hb1_x0 < w_hu2_x0 + C_HU_W) && (w_hu2_x0 < w_hb1_x0 + C_HB_W) &&
                 (w_hb1_y0 < w_hu2_y0 + C_HU_H) && (w_hu2_y0 < w_hb1_y0 + C_HB_H);
        w_ov21 = (w_hb2_x0 < w_hu1_x0 + C_HU_W) && (w_hu1_x0 < w_hb2_x0 + C_HB_W) &&
                 (w_hb2_y0 < w_hu1_y0 + C_HU_H) && (w_hu1_y0 < w_hb2_y0 + C_HB_H);
        // Both directions qualify from the same register snapshot so a trade lands both hits.
        w_q12 = r_s2 && r_hit12 && (r_state == ST_FIGHT) && !r_latch1 &&
                (r_stun1 == 8'd0) && (r_stun2 == 8'd0);
        w_q21 = r_s2 && r_hit21 && (r_state == ST_FIGHT) && !r_latch2 &&
                (r_stun2 == 8'd0) && (r_stun1 == 8'd0);
    end

    function automatic logic [7:0] sat_sub(input logic [7:0] hp);
        return (hp <= C_DMG) ? 8'd0 : hp - C_DMG;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_COUNTDOWN;
            r_timer  <= C_READY;
            r_hp1    <= C_HP;
            r_hp2    <= C_HP;
            r_stun1  <= 8'd0;
            r_stun2  <= 8'd0;
            r_latch1 <= 1'b0;
            r_latch2 <= 1'b0;
            r_hit12  <= 1'b0;
            r_hit21  <= 1'b0;
            r_s2     <= 1'b0;
            r_pulse1 <= 1'b0;
            r_pulse2 <= 1'b0;
            r_en1    <= 1'b0;
            r_en2    <= 1'b0;
            r_winner <= 2'b00;
        end else begin
            r_pulse1 <= 1'b0;
            r_pulse2 <= 1'b0;
            r_s2     <= SCEN;
            // Stage 1: capture raw hit candidates for this frame.
            if (SCEN) begin
                r_hit12 <= w_ov12 && p1_attack_damage;
                r_hit21 <= w_ov21 && p2_attack_damage;
            end
            if (SCEN && r_stun1 != 8'd0) r_stun1 <= r_stun1 - 8'd1;
            if (SCEN && r_stun2 != 8'd0) r_stun2 <= r_stun2 - 8'd1;
            if (SCEN && !p1_attack_active) r_latch1 <= 1'b0;
            if (SCEN && !p2_attack_active) r_latch2 <= 1'b0;
            // Stage 2: a landed hit overrides the same-clk decrement / latch clear.
            if (w_q12) begin
                r_hp2    <= sat_sub(r_hp2);
                r_stun2  <= C_STUN;
                r_pulse2 <= 1'b1;
                r_latch1 <= 1'b1;
            end
            if (w_q21) begin
                r_hp1    <= sat_sub(r_hp1);
                r_stun1  <= C_STUN;
                r_pulse1 <= 1'b1;
                r_latch2 <= 1'b1;
            end
            r_en1 <= (r_state == ST_FIGHT) && (r_stun1 == 8'd0);
            r_en2 <= (r_state == ST_FIGHT) && (r_stun2 == 8'd0);
            case (r_state)
                ST_COUNTDOWN: begin
                    if (SCEN) begin
                        if (r_timer == 8'd0) r_state <= ST_FIGHT;
                        else                 r_timer <= r_timer - 8'd1;
                    end
                end
                ST_FIGHT: begin
                    if (r_hp1 == 8'd0 || r_hp2 == 8'd0) begin
                        r_state  <= ST_KO;
                        r_timer  <= C_KO;
                        r_winner <= {r_hp1 == 8'd0, r_hp2 == 8'd0};
                    end
                end
                ST_KO: begin
                    if (SCEN) begin
                        if (r_timer == 8'd0) begin
                            r_state  <= ST_COUNTDOWN;
                            r_timer  <= C_READY;
                            r_hp1    <= C_HP;
                            r_hp2    <= C_HP;
                            r_stun1  <= 8'd0;
                            r_stun2  <= 8'd0;
                            r_latch1 <= 1'b0;
                            r_latch2 <= 1'b0;
                            r_winner <= 2'b00;
                        end else begin
                            r_timer <= r_timer - 8'd1;
                        end
                    end
                end
                default: r_state <= ST_COUNTDOWN;
            endcase
        end
    end

    assign p1_health    = r_hp1;
    assign p2_health    = r_hp2;
    assign p1_hitstun   = (r_stun1 != 8'd0);
    assign p2_hitstun   = (r_stun2 != 8'd0);
    assign p1_hit_pulse = r_pulse1;
    assign p2_hit_pulse = r_pulse2;
    assign p1_enable    = r_en1;
    assign p2_enable    = r_en2;
    assign round_state  = r_state;
    assign winner       = r_winner;

endmodule

// File: tb/tb_combat_round_ctrl.sv
// Directed bench for combat_round_ctrl. Instance dut_a uses default
// parameters; dut_b shares all stimulus but starts at HP 25 so the
// saturating-damage boundary (5 - 10 -> 0) can be reached.
module tb_combat_round_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic SCEN = 1'b0;
    logic [9:0] p1_pos_x = 10'd100, p2_pos_x = 10'd150;
    logic [9:0] p1_pos_y = 10'd100, p2_pos_y = 10'd100;
    logic p1_facing = 1'b1, p2_facing = 1'b0;
    logic p1_attack_active = 1'b0, p2_attack_active = 1'b0;
    logic p1_attack_damage = 1'b0, p2_attack_damage = 1'b0;

    logic [7:0] a_p1_health, a_p2_health, b_p1_health, b_p2_health;
    logic a_p1_hitstun, a_p2_hitstun, b_p1_hitstun, b_p2_hitstun;
    logic a_p1_hit_pulse, a_p2_hit_pulse, b_p1_hit_pulse, b_p2_hit_pulse;
    logic a_p1_enable, a_p2_enable, b_p1_enable, b_p2_enable;
    logic [1:0] a_round_state, a_winner, b_round_state, b_winner;

    int n_checks = 0;
    int n_pass = 0;
    int pc1_a = 0, pc2_a = 0, both_a = 0, pc2_b = 0, pc1_b = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    combat_round_ctrl dut_a (
        .clk(clk), .reset(reset), .SCEN(SCEN),
        .p1_pos_x(p1_pos_x), .p2_pos_x(p2_pos_x), .p1_pos_y(p1_pos_y), .p2_pos_y(p2_pos_y),
        .p1_facing(p1_facing), .p2_facing(p2_facing),
        .p1_attack_active(p1_attack_active), .p2_attack_active(p2_attack_active),
        .p1_attack_damage(p1_attack_damage), .p2_attack_damage(p2_attack_damage),
        .p1_health(a_p1_health), .p2_health(a_p2_health),
        .p1_hitstun(a_p1_hitstun), .p2_hitstun(a_p2_hitstun),
        .p1_hit_pulse(a_p1_hit_pulse), .p2_hit_pulse(a_p2_hit_pulse),
        .p1_enable(a_p1_enable), .p2_enable(a_p2_enable),
        .round_state(a_round_state), .winner(a_winner)
    );

    combat_round_ctrl #(.HP_MAX(25)) dut_b (
        .clk(clk), .reset(reset), .SCEN(SCEN),
        .p1_pos_x(p1_pos_x), .p2_pos_x(p2_pos_x), .p1_pos_y(p1_pos_y), .p2_pos_y(p2_pos_y),
        .p1_facing(p1_facing), .p2_facing(p2_facing),
        .p1_attack_active(p1_attack_active), .p2_attack_active(p2_attack_active),
        .p1_attack_damage(p1_attack_damage), .p2_attack_damage(p2_attack_damage),
        .p1_health(b_p1_health), .p2_health(b_p2_health),
        .p1_hitstun(b_p1_hitstun), .p2_hitstun(b_p2_hitstun),
        .p1_hit_pulse(b_p1_hit_pulse), .p2_hit_pulse(b_p2_hit_pulse),
        .p1_enable(b_p1_enable), .p2_enable(b_p2_enable),
        .round_state(b_round_state), .winner(b_winner)
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (a_p1_hit_pulse) pc1_a++;
        if (a_p2_hit_pulse) pc2_a++;
        if (a_p1_hit_pulse && a_p2_hit_pulse) both_a++;
        if (b_p1_hit_pulse) pc1_b++;
        if (b_p2_hit_pulse) pc2_b++;
    end

    task automatic frame();
        @(negedge clk); SCEN = 1'b1;
        @(negedge clk); SCEN = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic attack(input logic p1, input logic p2);
        p1_attack_active = p1; p1_attack_damage = p1;
        p2_attack_active = p2; p2_attack_damage = p2;
    endtask

    task automatic set_pos(input int x1, input int x2, input logic f1, input logic f2);
        p1_pos_x = 10'(x1); p2_pos_x = 10'(x2);
        p1_pos_y = 10'd100; p2_pos_y = 10'd100;
        p1_facing = f1; p2_facing = f2;
    endtask

    task automatic to_fight();
        attack(1'b0, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        frames(61);
    endtask

    task automatic test_reset();
        attack(1'b0, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        n_checks++; if (a_round_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", a_round_state); else n_pass++;
        n_checks++; if (a_p1_health !== 8'd100 || a_p2_health !== 8'd100) $display("FAIL rst_health: got %0d/%0d want 100/100", a_p1_health, a_p2_health); else n_pass++;
        n_checks++; if (b_p1_health !== 8'd25 || b_p2_health !== 8'd25) $display("FAIL rst_health_b: got %0d/%0d want 25/25", b_p1_health, b_p2_health); else n_pass++;
        n_checks++; if ({a_winner, b_winner, b_round_state} !== 6'd0) $display("FAIL rst_winner: got %0d/%0d/%0d want 0", a_winner, b_winner, b_round_state); else n_pass++;
        n_checks++; if ({a_p1_enable, a_p2_enable, b_p1_enable, b_p2_enable} !== 4'd0) $display("FAIL rst_enable: got %b want 0000", {a_p1_enable, a_p2_enable, b_p1_enable, b_p2_enable}); else n_pass++;
        n_checks++; if ({a_p1_hitstun, a_p2_hitstun, b_p1_hitstun, b_p2_hitstun, a_p1_hit_pulse, a_p2_hit_pulse, b_p1_hit_pulse, b_p2_hit_pulse} !== 8'd0) $display("FAIL rst_stun_pulse: got nonzero want 0"); else n_pass++;
        reset = 1'b0;
        frames(2);
        n_checks++; if (a_round_state !== 2'd0) $display("FAIL rst_countdown_hold: got %0d want 0", a_round_state); else n_pass++;
    endtask

    task automatic test_single_hit();
        int base;
        to_fight();
        n_checks++; if (a_round_state !== 2'd1) $display("FAIL t1_fight: got %0d want 1", a_round_state); else n_pass++;
        n_checks++; if ({a_p1_enable, a_p2_enable} !== 2'b11) $display("FAIL t1_enable: got %b want 11", {a_p1_enable, a_p2_enable}); else n_pass++;
        set_pos(100, 150, 1'b1, 1'b0);
        base = pc2_a;
        attack(1'b1, 1'b0);
        frame();
        n_checks++; if (a_p2_health !== 8'd90) $display("FAIL t1_health: got %0d want 90", a_p2_health); else n_pass++;
        n_checks++; if ({a_p2_hitstun, a_p2_enable, a_p1_enable} !== 3'b101) $display("FAIL t1_stun_en: got %b want 101", {a_p2_hitstun, a_p2_enable, a_p1_enable}); else n_pass++;
        for (int i = 0; i < 11; i++) begin
            if (i == 6) attack(1'b0, 1'b0);
            frame();
        end
        n_checks++; if (a_p2_hitstun !== 1'b1) $display("FAIL t1_stun_11: got %0d want 1", a_p2_hitstun); else n_pass++;
        n_checks++; if (a_p2_health !== 8'd90 || pc2_a - base !== 1) $display("FAIL t1_once: got health %0d pulses %0d want 90/1", a_p2_health, pc2_a - base); else n_pass++;
        frame();
        n_checks++; if ({a_p2_hitstun, a_p2_enable} !== 2'b01) $display("FAIL t1_stun_end: got %b want 01", {a_p2_hitstun, a_p2_enable}); else n_pass++;
    endtask

    task automatic test_facing_left();
        int base;
        to_fight();
        set_pos(100, 150, 1'b0, 1'b0);
        base = pc2_a;
        attack(1'b1, 1'b0);
        frames(7);
        attack(1'b0, 1'b0);
        frame();
        n_checks++; if (a_p2_health !== 8'd100 || pc2_a - base !== 0) $display("FAIL t2_no_hit: got health %0d pulses %0d want 100/0", a_p2_health, pc2_a - base); else n_pass++;
        n_checks++; if (a_p2_enable !== 1'b1) $display("FAIL t2_enable: got %0d want 1", a_p2_enable); else n_pass++;
    endtask

    task automatic test_trade();
        int b1, b2, bb;
        to_fight();
        set_pos(100, 150, 1'b1, 1'b0);
        b1 = pc1_a; b2 = pc2_a; bb = both_a;
        attack(1'b1, 1'b1);
        frame();
        n_checks++; if (a_p1_health !== 8'd90 || a_p2_health !== 8'd90) $display("FAIL t3_health: got %0d/%0d want 90/90", a_p1_health, a_p2_health); else n_pass++;
        n_checks++; if (pc1_a - b1 !== 1 || pc2_a - b2 !== 1 || both_a - bb !== 1) $display("FAIL t3_pulses: got %0d/%0d same %0d want 1/1 same 1", pc1_a - b1, pc2_a - b2, both_a - bb); else n_pass++;
        attack(1'b0, 1'b0);
        frame();
    endtask

    task automatic test_back_to_back();
        int base;
        to_fight();
        set_pos(100, 150, 1'b1, 1'b0);
        base = pc2_a;
        attack(1'b1, 1'b0);
        @(negedge clk); SCEN = 1'b1;
        @(negedge clk); SCEN = 1'b1;
        @(negedge clk); SCEN = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (a_p2_health !== 8'd90 || pc2_a - base !== 1) $display("FAIL b2b_once: got health %0d pulses %0d want 90/1", a_p2_health, pc2_a - base); else n_pass++;
        n_checks++; if (a_p2_hitstun !== 1'b1) $display("FAIL b2b_stun: got %0d want 1", a_p2_hitstun); else n_pass++;
        attack(1'b0, 1'b0);
        frame();
    endtask

    task automatic test_knockout();
        int base;
        logic [7:0] e;
        to_fight();
        set_pos(100, 150, 1'b1, 1'b0);
        for (int k = 9; k >= 0; k--) exp_q.push_back(8'(k * 10));
        for (int k = 0; k < 10; k++) begin
            attack(1'b1, 1'b0);
            frame();
            e = exp_q.pop_front();
            n_checks++; if (a_p2_health !== e) $display("FAIL ko_hit%0d: got %0d want %0d", k, a_p2_health, e); else n_pass++;
            if (k < 9) begin
                attack(1'b0, 1'b0);
                frames(12);
            end
        end
        n_checks++; if (a_round_state !== 2'd2 || a_winner !== 2'b01) $display("FAIL ko_state: got %0d winner %0d want 2/1", a_round_state, a_winner); else n_pass++;
        n_checks++; if ({a_p1_enable, a_p2_enable} !== 2'b00) $display("FAIL ko_enable: got %b want 00", {a_p1_enable, a_p2_enable}); else n_pass++;
        base = pc2_a;
        attack(1'b0, 1'b0);
        frame();
        attack(1'b1, 1'b0);
        frames(19);
        n_checks++; if (pc2_a - base !== 0 || a_p2_health !== 8'd0) $display("FAIL ko_ignore: got pulses %0d health %0d want 0/0", pc2_a - base, a_p2_health); else n_pass++;
        attack(1'b0, 1'b0);
        frames(99);
        n_checks++; if (a_round_state !== 2'd2) $display("FAIL ko_hold: got %0d want 2", a_round_state); else n_pass++;
        frames(2);
        n_checks++; if (a_round_state !== 2'd0 || a_winner !== 2'b00) $display("FAIL ko_restart: got %0d winner %0d want 0/0", a_round_state, a_winner); else n_pass++;
        n_checks++; if (a_p1_health !== 8'd100 || a_p2_health !== 8'd100) $display("FAIL ko_refill: got %0d/%0d want 100/100", a_p1_health, a_p2_health); else n_pass++;
        frames(59);
        n_checks++; if (a_round_state !== 2'd0) $display("FAIL ko_ready_hold: got %0d want 0", a_round_state); else n_pass++;
        frames(2);
        n_checks++; if (a_round_state !== 2'd1) $display("FAIL ko_refight: got %0d want 1", a_round_state); else n_pass++;
    endtask

    task automatic test_saturate();
        logic [7:0] exp_b[3];
        exp_b[0] = 8'd15; exp_b[1] = 8'd5; exp_b[2] = 8'd0;
        to_fight();
        set_pos(100, 150, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            attack(1'b1, 1'b0);
            frame();
            n_checks++; if (b_p2_health !== exp_b[k]) $display("FAIL sat_hit%0d: got %0d want %0d", k, b_p2_health, exp_b[k]); else n_pass++;
            attack(1'b0, 1'b0);
            if (k < 2) frames(12);
        end
        n_checks++; if (b_round_state !== 2'd2 || b_winner !== 2'b01) $display("FAIL sat_ko: got %0d winner %0d want 2/1", b_round_state, b_winner); else n_pass++;
    endtask

    task automatic test_reset_in_ko();
        frames(5);
        n_checks++; if (b_round_state !== 2'd2) $display("FAIL rko_pre: got %0d want 2", b_round_state); else n_pass++;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (b_round_state !== 2'd0 || b_winner !== 2'b00 || b_p2_health !== 8'd25) $display("FAIL rko_b: got %0d/%0d/%0d want 0/0/25", b_round_state, b_winner, b_p2_health); else n_pass++;
        n_checks++; if (a_round_state !== 2'd0 || a_p2_health !== 8'd100 || a_p1_health !== 8'd100) $display("FAIL rko_a: got %0d/%0d/%0d want 0/100/100", a_round_state, a_p1_health, a_p2_health); else n_pass++;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_facing_left();
        test_trade();
        test_back_to_back();
        test_knockout();
        test_saturate();
        test_reset_in_ko();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
